// File: rtl/status_display_pkg.sv
// Shared types for the status display controller: FSM states and
// classification of the sampled status vector.
package status_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        HOLD,
        CONFLICT
    } state_e;

    typedef enum logic [1:0] {
        NONE,
        ONEHOT,
        MULTI
    } cls_e;

endpackage

// File: rtl/status_display_ctrl_if.sv
// Status flags in, display drive out; the controller is the slave side.
interface status_display_ctrl_if #(
    parameter int N_STATUS = 4,
    parameter int CNT_W    = 8
);
    localparam int CW = $clog2(N_STATUS);

    logic [N_STATUS-1:0] status;
    logic                disp_on;
    logic [CW-1:0]       disp_code;
    logic                conflict;
    logic [CNT_W-1:0]    conflict_cnt;

    modport master (
        output status,
        input  disp_on, disp_code, conflict, conflict_cnt
    );

    modport slave (
        input  status,
        output disp_on, disp_code, conflict, conflict_cnt
    );
endinterface

// File: rtl/status_display_ctrl_classify.sv
// Combinational classifier: NONE / ONEHOT (with bit index) / MULTI.
import status_display_pkg::*;

module onehot_classify #(
    parameter int N_STATUS = 4
) (
    input  logic [N_STATUS-1:0]         status_i,
    output cls_e                        cls_o,
    output logic [$clog2(N_STATUS)-1:0] idx_o
);
    localparam int CW = $clog2(N_STATUS);

    logic seen;
    logic multi;

    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        idx_o = '0;
        for (int k = 0; k < N_STATUS; k++) begin
            if (status_i[k]) begin
                if (seen) multi = 1'b1;
                seen  = 1'b1;
                idx_o = CW'(k);
            end
        end
        cls_o = multi ? MULTI : (seen ? ONEHOT : NONE);
    end
endmodule

// File: rtl/status_display_ctrl.sv
// Display-enable controller: shows the active status flag, holds it after
// the flag drops, and blinks/counts illegal multi-flag conditions.
import status_display_pkg::*;

module status_display_ctrl #(
    parameter int N_STATUS    = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int BLINK_DIV   = 2,
    parameter int CNT_W       = 8
) (
    input logic                clk,
    input logic                reset,
    status_display_ctrl_if.slave sd
);
    localparam int CW = $clog2(N_STATUS);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    cls_e          cls;
    logic [CW-1:0] idx;

    onehot_classify #(.N_STATUS(N_STATUS)) u_classify (
        .status_i (sd.status),
        .cls_o    (cls),
        .idx_o    (idx)
    );

    state_e           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
    logic             blink_q, blink_d;
    logic [CW-1:0]    code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             on_q, on_d;
    logic             conf_q, conf_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            code_q      <= '0;
            cnt_q       <= '0;
            on_q        <= 1'b0;
            conf_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            code_q      <= code_d;
            cnt_q       <= cnt_d;
            on_q        <= on_d;
            conf_q      <= conf_d;
        end
    end

    // ONEHOT and MULTI decide the next state the same way from every state;
    // only NONE depends on where we are.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        code_d      = code_q;
        cnt_d       = cnt_q;
        if (cls == ONEHOT) begin
            state_d = SHOW;
            code_d  = idx;
        end else if (cls == MULTI) begin
            state_d = CONFLICT;
            if (state_q != CONFLICT) begin
                blink_d     = 1'b1;
                blink_cnt_d = '0;
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end else begin
            unique case (state_q)
                SHOW: begin
                    if (HOLD_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        hold_d  = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (hold_q == '0) state_d = IDLE;
                    else              hold_d  = hold_q - HW'(1);
                end
                default: state_d = IDLE;
            endcase
        end
        on_d   = (state_d == SHOW) || (state_d == HOLD) ||
                 ((state_d == CONFLICT) && blink_d);
        conf_d = (state_d == CONFLICT);
    end

    assign sd.disp_on      = on_q;
    assign sd.disp_code    = code_q;
    assign sd.conflict     = conf_q;
    assign sd.conflict_cnt = cnt_q;
endmodule
